// File: rtl/regbank_pkg.sv
// Shared defaults for the 2R/1W register bank.
// Data width, select width and reset value.
package regbank_pkg;

  localparam int WIDTH_DEF  = 16;
  localparam int ADDR_W_DEF = 3;

  localparam logic [WIDTH_DEF-1:0] RESVAL_DEF = '0;

endpackage

// File: rtl/regbank_scoreboard.sv
// Pending-write scoreboard, one busy bit per register.
// Issue sets, retire clears, issue wins on collision.
module regbank_scoreboard
  import regbank_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter bit ZERO_R0 = 1'b0,
  localparam int NREGS  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_sel,
  input  logic              wen,
  input  logic [ADDR_W-1:0] wsel,
  output logic [NREGS-1:0]  busy_vec
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // next busy: clear on retire, then set on issue
  always_comb begin
    busy_d = busy_q;
    if (wen) busy_d[wsel] = 1'b0;
    if (iss_en) busy_d[iss_sel] = 1'b1;
    if (ZERO_R0) busy_d[0] = 1'b0;
  end

  // busy bits, async clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/regbank_mp.sv
// 2-read/1-write register bank with write bypass
// and a pending-write scoreboard.
module regbank_mp
  import regbank_pkg::*;
#(
  parameter int              WIDTH   = WIDTH_DEF,
  parameter int              ADDR_W  = ADDR_W_DEF,
  parameter bit              ZERO_R0 = 1'b0,
  parameter bit              BYPASS  = 1'b1,
  parameter logic [WIDTH-1:0] RESVAL = WIDTH'(RESVAL_DEF),
  localparam int             NREGS   = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wen,
  input  logic [ADDR_W-1:0] wsel,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] rsel_a,
  output logic [WIDTH-1:0]  rdata_a,
  output logic              busy_a,
  input  logic [ADDR_W-1:0] rsel_b,
  output logic [WIDTH-1:0]  rdata_b,
  output logic              busy_b,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_sel,
  output logic [NREGS-1:0]  busy_vec
);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic             wr_ok;
  logic             fwd_a;
  logic             fwd_b;

  // r0 is hard-wired when ZERO_R0, so its writes are dropped
  assign wr_ok = wen && !(ZERO_R0 && wsel == '0);
  // no forwarding while reset holds the bank at RESVAL
  assign fwd_a = BYPASS && wr_ok && !reset && wsel == rsel_a;
  assign fwd_b = BYPASS && wr_ok && !reset && wsel == rsel_b;

  // next storage state: single write port
  always_comb begin
    regs_d = regs_q;
    if (wr_ok) regs_d[wsel] = wdata;
  end

  // storage array, async load of RESVAL
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= RESVAL;
    end else begin
      regs_q <= regs_d;
    end
  end

  regbank_scoreboard #(
    .ADDR_W  (ADDR_W),
    .ZERO_R0 (ZERO_R0)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .iss_en   (iss_en),
    .iss_sel  (iss_sel),
    .wen      (wen),
    .wsel     (wsel),
    .busy_vec (busy_vec)
  );

  // read muxes with forwarding and r0 masking
  always_comb begin
    rdata_a = regs_q[rsel_a];
    busy_a  = busy_vec[rsel_a];
    rdata_b = regs_q[rsel_b];
    busy_b  = busy_vec[rsel_b];
    if (fwd_a) begin
      rdata_a = wdata;
      busy_a  = 1'b0;
    end
    if (fwd_b) begin
      rdata_b = wdata;
      busy_b  = 1'b0;
    end
    if (ZERO_R0 && rsel_a == '0) rdata_a = '0;
    if (ZERO_R0 && rsel_b == '0) rdata_b = '0;
  end

endmodule

// File: tb/tb_regbank_mp.sv
// Directed bench for regbank_mp: one bypassing bank
// with hard-wired r0, one non-bypassing plain bank.
module tb_regbank_mp;

  localparam logic [15:0] RV = 16'h00A5;

  logic        clk = 1'b0;
  logic        reset;
  logic        wen;
  logic [2:0]  wsel;
  logic [15:0] wdata;
  logic [2:0]  rsel_a;
  logic [2:0]  rsel_b;
  logic        iss_en;
  logic [2:0]  iss_sel;

  logic [15:0] z_rd_a, z_rd_b, n_rd_a, n_rd_b;
  logic        z_bz_a, z_bz_b, n_bz_a, n_bz_b;
  logic [7:0]  z_vec, n_vec;

  int n_pass = 0;
  int n_tot  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regbank_mp #(
    .WIDTH(16), .ADDR_W(3), .ZERO_R0(1'b1),
    .BYPASS(1'b1), .RESVAL(RV)
  ) dut (
    .clk(clk), .reset(reset), .wen(wen),
    .wsel(wsel), .wdata(wdata),
    .rsel_a(rsel_a), .rdata_a(z_rd_a), .busy_a(z_bz_a),
    .rsel_b(rsel_b), .rdata_b(z_rd_b), .busy_b(z_bz_b),
    .iss_en(iss_en), .iss_sel(iss_sel), .busy_vec(z_vec)
  );

  regbank_mp #(
    .WIDTH(16), .ADDR_W(3), .ZERO_R0(1'b0),
    .BYPASS(1'b0), .RESVAL(RV)
  ) dut_nb (
    .clk(clk), .reset(reset), .wen(wen),
    .wsel(wsel), .wdata(wdata),
    .rsel_a(rsel_a), .rdata_a(n_rd_a), .busy_a(n_bz_a),
    .rsel_b(rsel_b), .rdata_b(n_rd_b), .busy_b(n_bz_b),
    .iss_en(iss_en), .iss_sel(iss_sel), .busy_vec(n_vec)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; wen = 1'b0; wsel = '0; wdata = '0;
    rsel_a = '0; rsel_b = '0; iss_en = 1'b0; iss_sel = '0;
    #1;
    chk("rst_rd_nb", n_rd_a, RV);
    chk("rst_rd_z0", z_rd_a, 0);
    chk("rst_vec", n_vec, 0);
    #11 reset = 1'b0;

    // 1: all registers at RESVAL, nothing busy
    nxt();
    for (int i = 0; i < 8; i++) begin
      rsel_a = 3'(i); rsel_b = 3'(i);
      #1;
      chk($sformatf("t1_nb_r%0d", i), n_rd_a, RV);
      chk($sformatf("t1_z_r%0d", i), z_rd_b, (i == 0) ? 0 : RV);
    end
    chk("t1_vec_z", z_vec, 0);
    chk("t1_vec_nb", n_vec, 0);

    // 2: write r3 with same-cycle read
    nxt();
    wen = 1'b1; wsel = 3'd3; wdata = 16'h1234; rsel_a = 3'd3;
    #1;
    chk("t2_byp", z_rd_a, 16'h1234);
    chk("t2_nobyp", n_rd_a, RV);
    nxt();
    wen = 1'b0;
    #1;
    chk("t2_nb_next", n_rd_a, 16'h1234);
    chk("t2_z_next", z_rd_a, 16'h1234);

    // 3: issue r5, two idle cycles, retire r5
    nxt();
    iss_en = 1'b1; iss_sel = 3'd5; rsel_b = 3'd5;
    #1;
    chk("t3_iss_cyc", z_bz_b, 0);
    nxt();
    iss_en = 1'b0;
    #1;
    chk("t3_idle1_z", z_bz_b, 1);
    chk("t3_idle1_nb", n_bz_b, 1);
    chk("t3_idle1_vec", z_vec, 8'h20);
    nxt();
    #1;
    chk("t3_idle2_z", z_bz_b, 1);
    nxt();
    wen = 1'b1; wsel = 3'd5; wdata = 16'hBEEF;
    #1;
    chk("t3_wr_bz_z", z_bz_b, 0);
    chk("t3_wr_rd_z", z_rd_b, 16'hBEEF);
    chk("t3_wr_bz_nb", n_bz_b, 1);
    chk("t3_wr_rd_nb", n_rd_b, RV);
    nxt();
    wen = 1'b0;
    #1;
    chk("t3_after_z", z_vec, 0);
    chk("t3_after_nb", n_vec, 0);
    chk("t3_after_rd", n_rd_b, 16'hBEEF);

    // 4: retire and re-issue r2 together
    nxt();
    iss_en = 1'b1; iss_sel = 3'd2;
    nxt();
    iss_en = 1'b0;
    #1;
    chk("t4_pre", n_vec, 8'h04);
    nxt();
    iss_en = 1'b1; iss_sel = 3'd2;
    wen = 1'b1; wsel = 3'd2; wdata = 16'h2222;
    nxt();
    iss_en = 1'b0; wen = 1'b0; rsel_a = 3'd2;
    #1;
    chk("t4_vec_z", z_vec, 8'h04);
    chk("t4_vec_nb", n_vec, 8'h04);
    chk("t4_rd_z", z_rd_a, 16'h2222);
    chk("t4_rd_nb", n_rd_a, 16'h2222);

    // 5: r0 ignores writes and issues when hard-wired
    nxt();
    wen = 1'b1; wsel = 3'd0; wdata = 16'hFFFF; rsel_a = 3'd0;
    #1;
    chk("t5_wr_rd", z_rd_a, 0);
    chk("t5_wr_bz", z_bz_a, 0);
    nxt();
    wen = 1'b0; iss_en = 1'b1; iss_sel = 3'd0;
    #1;
    chk("t5_rd_z", z_rd_a, 0);
    chk("t5_rd_nb", n_rd_a, 16'hFFFF);
    nxt();
    iss_en = 1'b0;
    #1;
    chk("t5_vec_z", z_vec, 8'h04);
    chk("t5_vec_nb", n_vec, 8'h05);
    chk("t5_bz_z", z_bz_a, 0);

    // 6: busy 1/4/7, write r6, then reset between edges
    nxt();
    iss_en = 1'b1; iss_sel = 3'd1;
    nxt();
    iss_sel = 3'd4;
    nxt();
    iss_sel = 3'd7;
    wen = 1'b1; wsel = 3'd6; wdata = 16'h0F0F;
    nxt();
    iss_en = 1'b0; wen = 1'b0; rsel_a = 3'd6; rsel_b = 3'd7;
    #1;
    chk("t6_vec_z", z_vec, 8'h96);
    chk("t6_vec_nb", n_vec, 8'h97);
    chk("t6_rd6", z_rd_a, 16'h0F0F);
    chk("t6_bz7", n_bz_b, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_rd_z", z_rd_a, RV);
    chk("t6_rst_rd_nb", n_rd_a, RV);
    chk("t6_rst_vec_z", z_vec, 0);
    chk("t6_rst_vec_nb", n_vec, 0);
    chk("t6_rst_bz", z_bz_b, 0);
    wen = 1'b1; wsel = 3'd6; wdata = 16'h1111;
    iss_en = 1'b1; iss_sel = 3'd6;
    #1;
    chk("t6_rst_nofwd", z_rd_a, RV);
    nxt();
    nxt();
    #1;
    chk("t6_rst_held", z_rd_a, RV);
    chk("t6_rst_held_vec", z_vec, 0);
    wen = 1'b0; iss_en = 1'b0;
    reset = 1'b0;
    nxt();
    #1;
    chk("t6_post_rd", n_rd_a, RV);
    chk("t6_post_vec", n_vec, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
